// File: rtl/grid_scanout.sv
// Character-cell bitmap scan-out: raster counters plus per-frame grid snapshot,
// emitting one registered pixel per clock with line/frame strobes.
module grid_scanout #(
    parameter int unsigned GRID_ROWS  = 30,
    parameter int unsigned GRID_COLS  = 40,
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned H_TOTAL    = 400,
    parameter int unsigned V_TOTAL    = 262,
    parameter int unsigned H_START    = 40,
    parameter int unsigned V_START    = 10,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
    output logic [23:0]                    video_rgb,
    output logic                           video_de,
    output logic                           video_hs,
    output logic                           video_vs,
    output logic [15:0]                    frame_count
);

    localparam int unsigned H_ACTIVE = GRID_COLS << CELL_SHIFT;
    localparam int unsigned V_ACTIVE = GRID_ROWS << CELL_SHIFT;
    localparam int unsigned N_CELLS  = GRID_ROWS * GRID_COLS;
    localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HCW      = HW + 1;
    localparam int unsigned VCW      = VW + 1;
    localparam int unsigned IW       = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    logic [HW-1:0]      h_cnt_q, h_cnt_d;
    logic [VW-1:0]      v_cnt_q, v_cnt_d;
    logic [N_CELLS-1:0] shadow_q, shadow_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [23:0]        rgb_q, rgb_d;
    logic               de_q, de_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;

    logic               h_wrap, v_wrap, frame_start;
    logic               h_act, v_act, active;
    logic [HW-1:0]      h_off, col;
    logic [VW-1:0]      v_off, row;
    logic [IW-1:0]      cell_idx;

    // Raster counters, frame counter and snapshot capture
    always_comb begin
        h_wrap        = (h_cnt_q == HW'(H_TOTAL - 1));
        v_wrap        = (v_cnt_q == VW'(V_TOTAL - 1));
        frame_start   = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_cnt_d       = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d       = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
        frame_count_d = frame_count_q;
        if (h_wrap && v_wrap) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        shadow_d      = frame_start ? grid_ram : shadow_q;
    end

    // Pixel generation; the cell index is only formed for active states so it stays in range
    always_comb begin
        h_act    = ({1'b0, h_cnt_q} >= HCW'(H_START)) &&
                   ({1'b0, h_cnt_q} <  HCW'(H_START + H_ACTIVE));
        v_act    = ({1'b0, v_cnt_q} >= VCW'(V_START)) &&
                   ({1'b0, v_cnt_q} <  VCW'(V_START + V_ACTIVE));
        active   = h_act && v_act;
        h_off    = h_cnt_q - HW'(H_START);
        v_off    = v_cnt_q - VW'(V_START);
        col      = h_off >> CELL_SHIFT;
        row      = v_off >> CELL_SHIFT;
        cell_idx = '0;
        if (active) begin
            cell_idx = IW'(row) * IW'(GRID_COLS) + IW'(col);
        end
        rgb_d = 24'h000000;
        if (active) begin
            rgb_d = shadow_d[cell_idx] ? FG_COLOR : BG_COLOR;
        end
        de_d = active;
        hs_d = (h_cnt_q == '0);
        vs_d = frame_start;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            shadow_q      <= '0;
            frame_count_q <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            shadow_q      <= shadow_d;
            frame_count_q <= frame_count_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign video_rgb   = rgb_q;
    assign video_de    = de_q;
    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign frame_count = frame_count_q;

endmodule
